fpga_switch_box: RTL and testbench
==================================

Name: fpga_switch_box

Overview:
- Parametrised four-sided routing switch box for the FPGA fabric, the successor to the fixed 5x4 matrix.
- Each output pin on each side selects any input pin on any side, or stays undriven.
- Routing configuration is no longer fixed at elaboration. It is loaded serially through a valid/ready handshake into a shadow chain, then committed atomically to the active configuration.
- Optional registered-output mode.
- Pins are split into in/out/oe per side; no inouts inside the box.

Parameters:
- TB_W, 5, pin count on the top and bottom sides.
- LR_W, 4, pin count on the left and right sides.
- IDX_W, 3, index field width; must satisfy 2**IDX_W >= max(TB_W, LR_W).
- REG_OUT, 0, 0 = combinational routing; 1 = out/oe registered (one-cycle latency).

Ports:
- clk  in  1  fabric clock
- rst_n  in  1  asynchronous active-low reset
- top_in / bottom_in  in  TB_W  pad input values
- left_in / right_in  in  LR_W  pad input values
- top_out, top_oe / bottom_out, bottom_oe  out  TB_W each  routed value and drive enable
- left_out, left_oe / right_out, right_oe  out  LR_W each
- cfg_data  in  1  serial config bit
- cfg_valid  in  1  cfg_data valid
- cfg_ready  out  1  shadow chain accepting bits
- cfg_full  out  1  shadow chain holds a complete image
- cfg_commit  in  1  copy shadow to active (single-cycle pulse)
- cfg_abort  in  1  discard partial load
- cfg_err  out  1  last committed image contained an invalid entry

Behaviour:
- Entry width E = 3 + IDX_W. N = 2*TB_W + 2*LR_W pins. Image length L = N*E bits (108 at defaults).
- Entry fields:
  - bits [2:0] side code: 0 off, 1 top, 2 right, 3 bottom, 4 left.
  - bits [E-1:3] source index.
- Entry order k: top[0..TB_W-1], bottom[0..TB_W-1], left[0..LR_W-1], right[0..LR_W-1].
  - Entry k occupies shadow bits [k*E +: E].
- Shift direction: each accepted bit enters at shadow MSB and shifts toward bit 0. The first streamed bit ends at bit 0 (top[0] side bit 0).
- FSM states:
  - IDLE: cfg_ready=1, bit counter=0. An accepted bit (cfg_valid & cfg_ready) moves to LOAD.
  - LOAD: cfg_ready=1. Counter increments on each accepted bit. The accept that makes the count L moves to FULL.
  - FULL: cfg_ready=0, cfg_full=1; further cfg_valid is ignored. cfg_commit moves to IDLE: active <= shadow and cfg_err is updated on that same edge; counter clears.
- cfg_commit is ignored in IDLE and LOAD, including when it coincides with the final bit. It is honoured only in FULL.
- cfg_abort in LOAD or FULL returns to IDLE with counter=0; active config is untouched. Abort wins over a simultaneous commit or accept.
- Routing per output pin with active entry (s, i):
  - s in 1..4 and i < width(side s): out = that side's in[i], oe = 1.
  - Otherwise: out = 0, oe = 0.
- Invalid entry: s in 5..7, or s in 1..4 with i out of range. cfg_err is set at commit if any entry is invalid, cleared at a commit with none.
- REG_OUT=1: out/oe sampled every clk, so routing changes one cycle after an input change or commit. REG_OUT=0: purely combinational from active config and inputs.
- Reset (async, any state, including mid-load): active = 0, shadow = 0, state IDLE, counter 0, cfg_ready=1, cfg_full=0, cfg_err=0, all out=0 and oe=0 (including registered copies).

Decomposition:
- Package fpga_sbox_pkg holds the side-code constants (SIDE_OFF, SIDE_TOP, SIDE_RIGHT, SIDE_BOTTOM, SIDE_LEFT), the cfg FSM state encoding, and E/N/L derivation functions.
- Sub-module sbox_pin_mux: one output pin. Takes entry plus the four side input buses; produces out, oe and entry-invalid. Instantiated N times by generate.
- The loader FSM and shift chain stay in the top module.

Test Plan:
- Reset then hold: all oe=0, out=0, cfg_ready=1, cfg_full=0, cfg_err=0.
- Load a default image with top[0] = 6'b010_100 (left[2]), all others 0, then commit. Drive left_in=4'b0100: top_out[0]=1, top_oe[0]=1, all other oe=0. Drive left_in=0: top_out[0]=0.
- Stream 108 bits with cfg_valid gaps: cfg_full rises the cycle after bit 108 and cfg_ready drops. A 109th bit is ignored. A commit pulse issued before bit 108 leaves active unchanged.
- Load 50 bits, assert cfg_abort: state IDLE, prior routing unchanged. A full reload plus commit then applies cleanly.
- Image with right[3] side code 6, or top[1] = (top, index 7): after commit cfg_err=1 and those pins have oe=0. A following clean commit clears cfg_err.
- Assert rst_n low at bit 70 of a load: outputs off immediately (async). After release, a full 108-bit load is required before cfg_full.
- REG_OUT=1 with top[0] = left[2] active: left_in[2] 0->1 appears on top_out[0] exactly one clk later.

Source files
------------

// File: rtl/fpga_sbox_pkg.sv
// Shared definitions for the four-sided FPGA switch box.
//   - Side codes used in the low three bits of every routing entry.
//   - Loader FSM state encoding.
//   - Helpers deriving entry width, pin count and serial image length.
package fpga_sbox_pkg;

  localparam logic [2:0] SIDE_OFF    = 3'd0;
  localparam logic [2:0] SIDE_TOP    = 3'd1;
  localparam logic [2:0] SIDE_RIGHT  = 3'd2;
  localparam logic [2:0] SIDE_BOTTOM = 3'd3;
  localparam logic [2:0] SIDE_LEFT   = 3'd4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLoad = 2'd1,
    StFull = 2'd2
  } cfg_state_e;

  // Entry = 3-bit side code followed by the source index field.
  function automatic int unsigned entry_width(input int unsigned idx_w);
    return 3 + idx_w;
  endfunction

  function automatic int unsigned pin_count(input int unsigned tb_w, input int unsigned lr_w);
    return 2 * tb_w + 2 * lr_w;
  endfunction

  function automatic int unsigned image_len(input int unsigned tb_w, input int unsigned lr_w,
                                            input int unsigned idx_w);
    return pin_count(tb_w, lr_w) * entry_width(idx_w);
  endfunction

endpackage

// File: rtl/sbox_pin_mux.sv
// One output pin of the switch box.
//   entry_i              : routing entry {source index, side code}
//   top_i / bottom_i     : top/bottom side pad inputs (TB_W)
//   left_i / right_i     : left/right side pad inputs (LR_W)
//   out_o / oe_o         : routed value and drive enable
//   invalid_o            : entry names a reserved side code or an out-of-range index
// IDX_W must be wide enough to address every pin of the wider side.
module sbox_pin_mux
  import fpga_sbox_pkg::*;
#(
  parameter int unsigned TB_W  = 5,
  parameter int unsigned LR_W  = 4,
  parameter int unsigned IDX_W = 3
) (
  input  logic [IDX_W+2:0] entry_i,
  input  logic [TB_W-1:0]  top_i,
  input  logic [TB_W-1:0]  bottom_i,
  input  logic [LR_W-1:0]  left_i,
  input  logic [LR_W-1:0]  right_i,
  output logic             out_o,
  output logic             oe_o,
  output logic             invalid_o
);

  logic [2:0]       side;
  logic [IDX_W-1:0] idx;

  assign side = entry_i[2:0];
  assign idx  = entry_i[IDX_W+2:3];

  logic tb_ok, lr_ok;
  logic top_bit, bottom_bit, left_bit, right_bit;

  // Index decode per side width; an index with no matching pin leaves *_ok low.
  always_comb begin
    tb_ok      = 1'b0;
    top_bit    = 1'b0;
    bottom_bit = 1'b0;
    for (int j = 0; j < int'(TB_W); j++) begin
      if (idx == IDX_W'(j)) begin
        tb_ok      = 1'b1;
        top_bit    = top_i[j];
        bottom_bit = bottom_i[j];
      end
    end
  end

  always_comb begin
    lr_ok     = 1'b0;
    left_bit  = 1'b0;
    right_bit = 1'b0;
    for (int j = 0; j < int'(LR_W); j++) begin
      if (idx == IDX_W'(j)) begin
        lr_ok     = 1'b1;
        left_bit  = left_i[j];
        right_bit = right_i[j];
      end
    end
  end

  always_comb begin
    out_o     = 1'b0;
    oe_o      = 1'b0;
    invalid_o = 1'b0;
    case (side)
      SIDE_OFF: ;
      SIDE_TOP: begin
        if (tb_ok) begin
          out_o = top_bit;
          oe_o  = 1'b1;
        end else begin
          invalid_o = 1'b1;
        end
      end
      SIDE_RIGHT: begin
        if (lr_ok) begin
          out_o = right_bit;
          oe_o  = 1'b1;
        end else begin
          invalid_o = 1'b1;
        end
      end
      SIDE_BOTTOM: begin
        if (tb_ok) begin
          out_o = bottom_bit;
          oe_o  = 1'b1;
        end else begin
          invalid_o = 1'b1;
        end
      end
      SIDE_LEFT: begin
        if (lr_ok) begin
          out_o = left_bit;
          oe_o  = 1'b1;
        end else begin
          invalid_o = 1'b1;
        end
      end
      default: invalid_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/fpga_switch_box.sv
// Four-sided routing switch box with serially loaded, atomically committed configuration.
//   clk, rst_n                     : fabric clock, asynchronous active-low reset
//   top_in/bottom_in (TB_W)        : pad inputs, top and bottom sides
//   left_in/right_in (LR_W)        : pad inputs, left and right sides
//   <side>_out, <side>_oe          : routed value and drive enable per output pin
//   cfg_data, cfg_valid, cfg_ready : serial shadow-chain load handshake
//   cfg_full                       : shadow chain holds a complete image
//   cfg_commit                     : copy shadow to active (honoured only when full)
//   cfg_abort                      : discard a partial or unconfirmed load
//   cfg_err                        : last committed image contained an invalid entry
module fpga_switch_box
  import fpga_sbox_pkg::*;
#(
  parameter int unsigned TB_W    = 5,
  parameter int unsigned LR_W    = 4,
  parameter int unsigned IDX_W   = 3,
  parameter int unsigned REG_OUT = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [TB_W-1:0] top_in,
  input  logic [TB_W-1:0] bottom_in,
  input  logic [LR_W-1:0] left_in,
  input  logic [LR_W-1:0] right_in,
  output logic [TB_W-1:0] top_out,
  output logic [TB_W-1:0] top_oe,
  output logic [TB_W-1:0] bottom_out,
  output logic [TB_W-1:0] bottom_oe,
  output logic [LR_W-1:0] left_out,
  output logic [LR_W-1:0] left_oe,
  output logic [LR_W-1:0] right_out,
  output logic [LR_W-1:0] right_oe,
  input  logic            cfg_data,
  input  logic            cfg_valid,
  output logic            cfg_ready,
  output logic            cfg_full,
  input  logic            cfg_commit,
  input  logic            cfg_abort,
  output logic            cfg_err
);

  localparam int unsigned EntryW   = entry_width(IDX_W);
  localparam int unsigned NumPins  = pin_count(TB_W, LR_W);
  localparam int unsigned ImageLen = image_len(TB_W, LR_W, IDX_W);
  localparam int unsigned CntW     = $clog2(ImageLen + 1);

  // Pin numbering inside the image: top, bottom, left, right.
  localparam int unsigned BotLo   = TB_W;
  localparam int unsigned LeftLo  = 2 * TB_W;
  localparam int unsigned RightLo = 2 * TB_W + LR_W;

  cfg_state_e          state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [ImageLen-1:0] shadow_q, shadow_d;
  logic [ImageLen-1:0] active_q, active_d;
  logic                accept;

  assign cfg_ready = (state_q != StFull);
  assign cfg_full  = (state_q == StFull);
  // Abort suppresses a coincident bit so a discarded load never leaves a stray shift.
  assign accept    = cfg_valid & cfg_ready & ~cfg_abort;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    active_d = active_q;

    // New bits enter at the MSB so the first streamed bit lands at bit 0.
    if (accept) begin
      shadow_d = {cfg_data, shadow_q[ImageLen-1:1]};
    end

    case (state_q)
      StIdle: begin
        if (accept) begin
          cnt_d   = CntW'(1);
          state_d = StLoad;
        end
      end
      StLoad: begin
        if (cfg_abort) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else if (accept) begin
          cnt_d = cnt_q + CntW'(1);
          if (cnt_q == CntW'(ImageLen - 1)) begin
            state_d = StFull;
          end
        end
      end
      StFull: begin
        if (cfg_abort) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else if (cfg_commit) begin
          active_d = shadow_q;
          cnt_d    = '0;
          state_d  = StIdle;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      shadow_q <= '0;
      active_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end

  logic [NumPins-1:0] pin_out, pin_oe, pin_bad;

  for (genvar k = 0; k < int'(NumPins); k++) begin : g_pin
    sbox_pin_mux #(
      .TB_W (TB_W),
      .LR_W (LR_W),
      .IDX_W(IDX_W)
    ) u_mux (
      .entry_i  (active_q[k*EntryW +: EntryW]),
      .top_i    (top_in),
      .bottom_i (bottom_in),
      .left_i   (left_in),
      .right_i  (right_in),
      .out_o    (pin_out[k]),
      .oe_o     (pin_oe[k]),
      .invalid_o(pin_bad[k])
    );
  end

  // Derived from the active image, so it changes exactly on the commit edge.
  assign cfg_err = |pin_bad;

  logic [NumPins-1:0] drv_out, drv_oe;

  if (REG_OUT != 0) begin : g_reg_out
    logic [NumPins-1:0] out_q, oe_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        out_q <= '0;
        oe_q  <= '0;
      end else begin
        out_q <= pin_out;
        oe_q  <= pin_oe;
      end
    end

    assign drv_out = out_q;
    assign drv_oe  = oe_q;
  end else begin : g_comb_out
    assign drv_out = pin_out;
    assign drv_oe  = pin_oe;
  end

  assign top_out    = drv_out[TB_W-1:0];
  assign top_oe     = drv_oe[TB_W-1:0];
  assign bottom_out = drv_out[BotLo +: TB_W];
  assign bottom_oe  = drv_oe[BotLo +: TB_W];
  assign left_out   = drv_out[LeftLo +: LR_W];
  assign left_oe    = drv_oe[LeftLo +: LR_W];
  assign right_out  = drv_out[RightLo +: LR_W];
  assign right_oe   = drv_oe[RightLo +: LR_W];

endmodule

// File: tb/tb_fpga_switch_box.sv
module tb_fpga_switch_box;

  localparam int TB_W  = 5;
  localparam int LR_W  = 4;
  localparam int IDX_W = 3;
  localparam int E     = 6;
  localparam int N     = 18;
  localparam int L     = 108;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [TB_W-1:0] top_in, bottom_in;
  logic [LR_W-1:0] left_in, right_in;
  logic            cfg_data, cfg_valid, cfg_commit, cfg_abort;

  logic [TB_W-1:0] c_top_out, c_top_oe, c_bottom_out, c_bottom_oe;
  logic [LR_W-1:0] c_left_out, c_left_oe, c_right_out, c_right_oe;
  logic            c_cfg_ready, c_cfg_full, c_cfg_err;
  logic [TB_W-1:0] r_top_out, r_top_oe, r_bottom_out, r_bottom_oe;
  logic [LR_W-1:0] r_left_out, r_left_oe, r_right_out, r_right_oe;
  logic            r_cfg_ready, r_cfg_full, r_cfg_err;

  always #5 clk = ~clk;

  fpga_switch_box #(
    .TB_W(TB_W), .LR_W(LR_W), .IDX_W(IDX_W), .REG_OUT(0)
  ) u_dut_comb (
    .clk(clk), .rst_n(rst_n),
    .top_in(top_in), .bottom_in(bottom_in), .left_in(left_in), .right_in(right_in),
    .top_out(c_top_out), .top_oe(c_top_oe), .bottom_out(c_bottom_out), .bottom_oe(c_bottom_oe),
    .left_out(c_left_out), .left_oe(c_left_oe), .right_out(c_right_out), .right_oe(c_right_oe),
    .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(c_cfg_ready), .cfg_full(c_cfg_full),
    .cfg_commit(cfg_commit), .cfg_abort(cfg_abort), .cfg_err(c_cfg_err)
  );

  fpga_switch_box #(
    .TB_W(TB_W), .LR_W(LR_W), .IDX_W(IDX_W), .REG_OUT(1)
  ) u_dut_reg (
    .clk(clk), .rst_n(rst_n),
    .top_in(top_in), .bottom_in(bottom_in), .left_in(left_in), .right_in(right_in),
    .top_out(r_top_out), .top_oe(r_top_oe), .bottom_out(r_bottom_out), .bottom_oe(r_bottom_oe),
    .left_out(r_left_out), .left_oe(r_left_oe), .right_out(r_right_out), .right_oe(r_right_oe),
    .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(r_cfg_ready), .cfg_full(r_cfg_full),
    .cfg_commit(cfg_commit), .cfg_abort(cfg_abort), .cfg_err(r_cfg_err)
  );

  logic [35:0] c_all, r_all;
  assign c_all = {c_top_oe, c_top_out, c_bottom_oe, c_bottom_out,
                  c_left_oe, c_left_out, c_right_oe, c_right_out};
  assign r_all = {r_top_oe, r_top_out, r_bottom_oe, r_bottom_out,
                  r_left_oe, r_left_out, r_right_oe, r_right_out};

  int tests = 0;
  int fails = 0;

  // Reference state: committed entries, the image being streamed, and load progress.
  logic [5:0]  model_act [N];
  logic [5:0]  img_e [N];
  int          model_cnt;
  bit          model_full;
  logic [35:0] exp_all;
  logic        model_err;

  function automatic int side_width(input int s);
    return (s == 1 || s == 3) ? TB_W : LR_W;
  endfunction

  function automatic bit ref_bad(input logic [5:0] e);
    int s, i;
    s = int'(e[2:0]);
    i = int'(e[5:3]);
    if (s == 0) return 1'b0;
    if (s > 4) return 1'b1;
    return i >= side_width(s);
  endfunction

  // Returns {oe, out} for one entry given the current pad inputs.
  function automatic logic [1:0] ref_pin(input logic [5:0] e);
    int s, i;
    logic [7:0] v;
    s = int'(e[2:0]);
    i = int'(e[5:3]);
    if (s == 0 || ref_bad(e)) return 2'b00;
    case (s)
      1:       v = 8'(top_in) >> i;
      2:       v = 8'(right_in) >> i;
      3:       v = 8'(bottom_in) >> i;
      default: v = 8'(left_in) >> i;
    endcase
    return {1'b1, v[0]};
  endfunction

  task automatic calc_exp();
    logic [TB_W-1:0] t_out, t_oe, b_out, b_oe;
    logic [LR_W-1:0] l_out, l_oe, q_out, q_oe;
    logic [1:0] r;
    for (int j = 0; j < TB_W; j++) begin
      r = ref_pin(model_act[j]);          {t_oe[j], t_out[j]} = r;
      r = ref_pin(model_act[TB_W + j]);   {b_oe[j], b_out[j]} = r;
    end
    for (int j = 0; j < LR_W; j++) begin
      r = ref_pin(model_act[2*TB_W + j]);        {l_oe[j], l_out[j]} = r;
      r = ref_pin(model_act[2*TB_W + LR_W + j]); {q_oe[j], q_out[j]} = r;
    end
    exp_all = {t_oe, t_out, b_oe, b_out, l_oe, l_out, q_oe, q_out};
    model_err = 1'b0;
    for (int k = 0; k < N; k++) if (ref_bad(model_act[k])) model_err = 1'b1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_comb(input string tag);
    calc_exp();
    chk({tag, "/route"}, 64'(c_all), 64'(exp_all));
    chk({tag, "/err"}, 64'(c_cfg_err), 64'(model_err));
  endtask

  task automatic check_reg(input string tag);
    calc_exp();
    chk({tag, "/reg_route"}, 64'(r_all), 64'(exp_all));
    chk({tag, "/reg_err"}, 64'(r_cfg_err), 64'(model_err));
  endtask

  task automatic check_flags(input string tag);
    chk({tag, "/ready"}, 64'(c_cfg_ready), 64'(!model_full));
    chk({tag, "/full"}, 64'(c_cfg_full), 64'(model_full));
    chk({tag, "/reg_ready"}, 64'(r_cfg_ready), 64'(!model_full));
    chk({tag, "/reg_full"}, 64'(r_cfg_full), 64'(model_full));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_inputs();
    top_in    = 5'($urandom);
    bottom_in = 5'($urandom);
    left_in   = 4'($urandom);
    right_in  = 4'($urandom);
  endtask

  task automatic clear_image();
    for (int k = 0; k < N; k++) img_e[k] = 6'd0;
  endtask

  task automatic rand_image(input bit allow_bad);
    int s, i, w;
    for (int k = 0; k < N; k++) begin
      s = int'($urandom_range(4, 0));
      w = side_width(s);
      i = int'($urandom_range(w - 1, 0));
      if (allow_bad && $urandom_range(5, 0) == 0) begin
        if ($urandom_range(1, 0) == 0) s = int'($urandom_range(7, 5));
        else begin
          s = int'($urandom_range(4, 1));
          i = int'($urandom_range(7, side_width(s)));
        end
      end
      img_e[k] = {3'(i), 3'(s)};
    end
  endtask

  // Streams image bits [first, first+count) with random idle gaps.
  task automatic stream(input int first, input int count, input int gap_max);
    logic [5:0] e;
    for (int j = first; j < first + count; j++) begin
      repeat ($urandom_range(gap_max, 0)) tick();
      e = img_e[j / E] >> (j % E);
      cfg_data  = e[0];
      cfg_valid = 1'b1;
      tick();
      cfg_valid = 1'b0;
      if (!model_full) begin
        model_cnt++;
        if (model_cnt == L) model_full = 1'b1;
      end
    end
  endtask

  task automatic commit();
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    if (model_full) begin
      model_act  = img_e;
      model_full = 1'b0;
      model_cnt  = 0;
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) model_act[k] = 6'd0;
    model_cnt  = 0;
    model_full = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; cfg_data = 1'b0; cfg_valid = 1'b0; cfg_commit = 1'b0; cfg_abort = 1'b0;
    top_in = '1; bottom_in = '1; left_in = '1; right_in = '1;
    model_reset();
    clear_image();

    // Reset hold
    #12;
    check_comb("rst_hold");
    check_reg("rst_hold");
    check_flags("rst_hold");
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();
    check_flags("rst_release");

    // top[0] <- left[2]
    clear_image();
    img_e[0] = 6'b010_100;
    left_in = 4'b0100; top_in = '0; bottom_in = '0; right_in = '0;
    stream(0, L, 0);
    check_flags("dflt_full");
    commit();
    @(negedge clk);
    check_comb("left2_hi");
    chk("left2_hi/top_out0", 64'(c_top_out[0]), 64'd1);
    chk("left2_hi/top_oe", 64'(c_top_oe), 64'd1);
    tick();
    @(negedge clk);
    check_reg("left2_hi");

    // Registered output latency, both edges of left_in[2]
    tick();
    left_in = 4'b0000;
    @(negedge clk);
    check_comb("left2_lo");
    chk("lat_fall/old", 64'(r_top_out[0]), 64'd1);
    tick();
    @(negedge clk);
    chk("lat_fall/new", 64'(r_top_out[0]), 64'd0);
    tick();
    left_in = 4'b0100;
    @(negedge clk);
    chk("lat_rise/old", 64'(r_top_out[0]), 64'd0);
    tick();
    @(negedge clk);
    chk("lat_rise/new", 64'(r_top_out[0]), 64'd1);
    check_reg("lat_rise");

    // Gapped stream, early commit ignored, 109th bit ignored
    tick();
    rand_image(1'b0);
    stream(0, L - 1, 3);
    check_flags("pre_last");
    commit();
    rand_inputs();
    @(negedge clk);
    check_comb("early_commit");
    tick();
    cfg_commit = 1'b1;
    stream(L - 1, 1, 0);
    cfg_commit = 1'b0;
    check_flags("full_rise");
    check_comb("commit_with_last");
    cfg_data = 1'b1; cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    check_flags("bit109");
    commit();
    check_flags("after_commit");
    @(negedge clk);
    check_comb("gap_commit");

    // Abort mid-load and from full
    tick();
    rand_image(1'b0);
    stream(0, 50, 1);
    cfg_abort = 1'b1;
    tick();
    cfg_abort = 1'b0;
    model_cnt = 0; model_full = 1'b0;
    check_flags("abort_load");
    rand_inputs();
    @(negedge clk);
    check_comb("abort_keep");
    tick();
    stream(0, L, 0);
    cfg_abort = 1'b1; cfg_commit = 1'b1;
    tick();
    cfg_abort = 1'b0; cfg_commit = 1'b0;
    model_cnt = 0; model_full = 1'b0;
    check_flags("abort_full");
    @(negedge clk);
    check_comb("abort_full_keep");
    tick();
    stream(0, L, 1);
    commit();
    @(negedge clk);
    check_comb("reload");

    // Invalid entries set cfg_err and stay undriven; a clean image clears it
    tick();
    rand_image(1'b0);
    img_e[2*TB_W + LR_W + 3] = {3'd0, 3'd6};
    img_e[1] = {3'd7, 3'd1};
    stream(0, L, 0);
    commit();
    rand_inputs();
    @(negedge clk);
    check_comb("err_img");
    chk("err_img/flag", 64'(c_cfg_err), 64'd1);
    chk("err_img/top_oe1", 64'(c_top_oe[1]), 64'd0);
    chk("err_img/right_oe3", 64'(c_right_oe[3]), 64'd0);
    tick();
    @(negedge clk);
    check_reg("err_img");
    tick();
    rand_image(1'b0);
    stream(0, L, 2);
    commit();
    @(negedge clk);
    check_comb("err_clear");

    // Random images, some with invalid entries, under random pad inputs
    repeat (6) begin
      tick();
      rand_image(1'b1);
      stream(0, L, 2);
      commit();
      repeat (4) begin
        tick();
        rand_inputs();
        @(negedge clk);
        check_comb("rand");
        tick();
        @(negedge clk);
        check_reg("rand");
      end
    end

    // Asynchronous reset in the middle of a load
    tick();
    clear_image();
    img_e[0] = 6'b010_100;
    stream(0, L, 0);
    commit();
    rand_inputs();
    left_in = 4'b0100;
    tick();
    tick();
    rand_image(1'b0);
    stream(0, 70, 0);
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_comb("async_rst");
    check_reg("async_rst");
    check_flags("async_rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();
    stream(0, L - 1, 0);
    check_flags("no_stale_cnt");
    stream(L - 1, 1, 0);
    check_flags("post_rst_full");
    commit();
    @(negedge clk);
    check_comb("post_rst_commit");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
